// File: rtl/ni_flit_injector_pkg.sv
// Shared NoC package: per-instance configuration, endpoint channel type,
// injector FSM states and head-flit field helpers.
package ni_flit_injector_pkg;

  localparam int MAX_V    = 4;
  localparam int MAX_FPAY = 64;
  localparam int MAX_EAW  = 16;

  // NoC instance table, indexed by NOC_ID.
  function automatic int noc_v(input int id);
    case (id)
      2:       return 4;
      default: return 2;
    endcase
  endfunction

  function automatic int noc_b(input int id);
    case (id)
      1:       return 2;
      2:       return 8;
      default: return 4;
    endcase
  endfunction

  function automatic int noc_fpay(input int id);
    case (id)
      2:       return 64;
      default: return 32;
    endcase
  endfunction

  function automatic int noc_eaw(input int id);
    case (id)
      2:       return 6;
      default: return 4;
    endcase
  endfunction

  // Endpoint channel of fattree_noc_top; the instantiating NI packs into it.
  typedef struct packed {
    logic                flit_wr;
    logic                flit_hd;
    logic                flit_tl;
    logic [MAX_V-1:0]    flit_vc;
    logic [MAX_FPAY-1:0] flit_pld;
    logic [MAX_V-1:0]    credit;
  } smartflit_chanel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } inj_state_t;

  function automatic logic [MAX_EAW-1:0] hdr_mask(input int eaw);
    return MAX_EAW'((32'd1 << eaw) - 32'd1);
  endfunction

  // Head payload: destination above the source, source in the LSBs.
  function automatic logic [MAX_FPAY-1:0] hdr_pack(input logic [MAX_EAW-1:0] dest,
                                                   input logic [MAX_EAW-1:0] src,
                                                   input int eaw);
    logic [MAX_EAW-1:0] mask;
    mask = hdr_mask(eaw);
    return (MAX_FPAY'(dest & mask) << eaw) | MAX_FPAY'(src & mask);
  endfunction

  function automatic logic [MAX_EAW-1:0] hdr_src(input logic [MAX_FPAY-1:0] pld,
                                                 input int eaw);
    return MAX_EAW'(pld) & hdr_mask(eaw);
  endfunction

  function automatic logic [MAX_EAW-1:0] hdr_dest(input logic [MAX_FPAY-1:0] pld,
                                                  input int eaw);
    return MAX_EAW'(pld >> eaw) & hdr_mask(eaw);
  endfunction

endpackage

// File: rtl/ni_credit_counter.sv
// One VC's credit counter: sends decrement, returned credits increment,
// and a credit returned while already full raises a sticky error.
module ni_credit_counter
  import ni_flit_injector_pkg::*;
#(
  parameter int B  = 4,
  parameter int CW = $clog2(B + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_send,
  input  logic          i_credit,
  output logic [CW-1:0] o_count,
  output logic          o_err
);

  logic [CW-1:0] r_count;
  logic          r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= CW'(B);
      r_err   <= 1'b0;
    end else begin
      case ({i_send, i_credit})
        2'b10: begin
          if (r_count != '0) r_count <= r_count - CW'(1);
        end
        2'b01: begin
          // Overflowing credit is dropped but remembered.
          if (r_count == CW'(B)) r_err <= 1'b1;
          else                   r_count <= r_count + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign o_count = r_count;
  assign o_err   = r_err;

endmodule

// File: rtl/ni_flit_injector.sv
// Network-interface flit injector: turns a packet request plus payload words
// into head/body/tail flits on one credit-available VC.
module ni_flit_injector
  import ni_flit_injector_pkg::*;
#(
  parameter int  NOC_ID  = 0,
  parameter int  EP_ID   = 0,
  parameter int  MAX_PKT = 16,
  localparam int V       = noc_v(NOC_ID),
  localparam int B       = noc_b(NOC_ID),
  localparam int FPAY    = noc_fpay(NOC_ID),
  localparam int EAW     = noc_eaw(NOC_ID),
  localparam int SW      = $clog2(MAX_PKT + 1),
  localparam int CW      = $clog2(B + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pkt_valid,
  output logic            pkt_ready,
  input  logic [EAW-1:0]  pkt_dest,
  input  logic [SW-1:0]   pkt_size,
  input  logic            dat_valid,
  output logic            dat_ready,
  input  logic [FPAY-1:0] dat_in,
  output logic            flit_wr,
  output logic            flit_hd,
  output logic            flit_tl,
  output logic [V-1:0]    flit_vc,
  output logic [FPAY-1:0] flit_pld,
  input  logic [V-1:0]    credit_in,
  output logic            busy,
  output logic            cred_err
);

  inj_state_t     r_state;
  logic [EAW-1:0] r_dest;
  logic [SW-1:0]  r_size;
  logic [SW-1:0]  r_left;
  logic [V-1:0]   r_vc;

  logic [CW-1:0]   w_cred_cnt [V];
  logic [V-1:0]    w_has_cred;
  logic [V-1:0]    w_cnt_err;
  logic [V-1:0]    w_send;
  logic [V-1:0]    w_first_vc;
  logic [SW-1:0]   w_size_clamped;
  logic [FPAY-1:0] w_head_pld;
  logic            w_pkt_cred;
  logic            w_head_go;
  logic            w_body_go;
  logic            w_accept;

  genvar gi;
  generate
    for (gi = 0; gi < V; gi++) begin : g_vc
      ni_credit_counter #(
        .B  (B),
        .CW (CW)
      ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .i_send   (w_send[gi]),
        .i_credit (credit_in[gi]),
        .o_count  (w_cred_cnt[gi]),
        .o_err    (w_cnt_err[gi])
      );
      assign w_has_cred[gi] = (w_cred_cnt[gi] != '0);
      assign w_send[gi]     = flit_wr & r_vc[gi];
    end
  endgenerate

  // Isolate the lowest set bit: lowest-index VC that still has credit.
  assign w_first_vc = w_has_cred & (~w_has_cred + V'(1));

  always_comb begin
    w_size_clamped = pkt_size;
    if (pkt_size == '0)              w_size_clamped = SW'(1);
    else if (pkt_size > SW'(MAX_PKT)) w_size_clamped = SW'(MAX_PKT);
  end

  assign w_head_pld = FPAY'(hdr_pack(MAX_EAW'(r_dest), MAX_EAW'(EP_ID), EAW));
  assign w_pkt_cred = |(r_vc & w_has_cred);

  assign pkt_ready = !reset && (r_state == ST_IDLE) && (|w_has_cred);
  assign dat_ready = !reset && (r_state == ST_BODY) && w_pkt_cred;
  assign w_accept  = pkt_valid && pkt_ready;
  assign w_head_go = !reset && (r_state == ST_HEAD) && w_pkt_cred;
  assign w_body_go = dat_valid && dat_ready;

  assign flit_wr  = w_head_go || w_body_go;
  assign flit_hd  = w_head_go;
  assign flit_tl  = w_head_go ? (r_size == SW'(1)) : (w_body_go && (r_left == SW'(1)));
  assign flit_vc  = flit_wr ? r_vc : '0;
  assign flit_pld = w_head_go ? w_head_pld : (w_body_go ? dat_in : '0);
  assign busy     = !reset && (r_state != ST_IDLE);
  assign cred_err = |w_cnt_err;

  // r_left counts body flits still owed after the head has gone.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_dest  <= '0;
      r_size  <= '0;
      r_left  <= '0;
      r_vc    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_dest  <= pkt_dest;
            r_size  <= w_size_clamped;
            r_vc    <= w_first_vc;
            r_state <= ST_HEAD;
          end
        end
        ST_HEAD: begin
          if (w_head_go) begin
            r_left  <= r_size - SW'(1);
            r_state <= (r_size == SW'(1)) ? ST_IDLE : ST_BODY;
          end
        end
        ST_BODY: begin
          if (w_body_go) begin
            r_left <= r_left - SW'(1);
            if (r_left == SW'(1)) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ni_flit_injector.sv
// Directed bench: NOC 0 (V=2,B=4) instance for most cases, NOC 1 (B=2)
// instance for the credit-stall case; both share the same stimulus.
module tb_ni_flit_injector;

  localparam int V  = 2;
  localparam int FP = 32;
  localparam int EA = 4;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pkt_valid = 1'b0;
  logic [EA-1:0] pkt_dest = '0;
  logic [SW-1:0] pkt_size = '0;
  logic          dat_valid = 1'b0;
  logic [FP-1:0] dat_in = '0;
  logic [V-1:0]  credit_in = '0;

  logic          d0_pkt_ready, d0_dat_ready, d0_flit_wr, d0_flit_hd, d0_flit_tl, d0_busy, d0_cred_err;
  logic [V-1:0]  d0_flit_vc;
  logic [FP-1:0] d0_flit_pld;
  logic          d1_pkt_ready, d1_dat_ready, d1_flit_wr, d1_flit_hd, d1_flit_tl, d1_busy, d1_cred_err;
  logic [V-1:0]  d1_flit_vc;
  logic [FP-1:0] d1_flit_pld;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  ni_flit_injector #(.NOC_ID(0), .EP_ID(2), .MAX_PKT(16)) d0 (
    .clk(clk), .reset(reset),
    .pkt_valid(pkt_valid), .pkt_ready(d0_pkt_ready), .pkt_dest(pkt_dest), .pkt_size(pkt_size),
    .dat_valid(dat_valid), .dat_ready(d0_dat_ready), .dat_in(dat_in),
    .flit_wr(d0_flit_wr), .flit_hd(d0_flit_hd), .flit_tl(d0_flit_tl),
    .flit_vc(d0_flit_vc), .flit_pld(d0_flit_pld),
    .credit_in(credit_in), .busy(d0_busy), .cred_err(d0_cred_err)
  );

  ni_flit_injector #(.NOC_ID(1), .EP_ID(2), .MAX_PKT(16)) d1 (
    .clk(clk), .reset(reset),
    .pkt_valid(pkt_valid), .pkt_ready(d1_pkt_ready), .pkt_dest(pkt_dest), .pkt_size(pkt_size),
    .dat_valid(dat_valid), .dat_ready(d1_dat_ready), .dat_in(dat_in),
    .flit_wr(d1_flit_wr), .flit_hd(d1_flit_hd), .flit_tl(d1_flit_tl),
    .flit_vc(d1_flit_vc), .flit_pld(d1_flit_pld),
    .credit_in(credit_in), .busy(d1_busy), .cred_err(d1_cred_err)
  );

  always @(negedge clk) begin
    if (d0_flit_wr)
      $display("d0 flit hd=%0b tl=%0b vc=%b pld=%08h", d0_flit_hd, d0_flit_tl, d0_flit_vc, d0_flit_pld);
    if (d1_flit_wr)
      $display("d1 flit hd=%0b tl=%0b vc=%b pld=%08h", d1_flit_hd, d1_flit_tl, d1_flit_vc, d1_flit_pld);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; pkt_valid = 1'b0; dat_valid = 1'b0; credit_in = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic give_credit(input logic [V-1:0] mask, input int n);
    credit_in = mask;
    for (int i = 0; i < n; i++) tick();
    credit_in = '0;
  endtask

  // Sends one packet on d0 without per-flit checks, bounded by a cycle budget.
  task automatic send_quiet(input logic [EA-1:0] dest, input logic [SW-1:0] size);
    bit done = 1'b0;
    pkt_dest = dest; pkt_size = size; pkt_valid = 1'b1; dat_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (d0_flit_wr && d0_flit_tl) done = 1'b1;
      tick();
    end
    dat_valid = 1'b0;
    chk("send_quiet_done", done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset = 1'b1;
    tick();
    #1;
    chk("rst_pkt_ready", d0_pkt_ready, 1'b0);
    chk("rst_dat_ready", d0_dat_ready, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", d0_busy, 1'b0);
    chk("rst_flit_wr", d0_flit_wr, 1'b0);
    chk("rst_flit_vc", d0_flit_vc, 2'b00);
    chk("rst_cred_err", d0_cred_err, 1'b0);
    chk("rst_cnt0", d0.w_cred_cnt[0], 3'd4);
    chk("rst_cnt1", d0.w_cred_cnt[1], 3'd4);
    chk("rst_idle_ready", d0_pkt_ready, 1'b1);
    tick();

    // Size 3 to dest 5: head/body/tail on VC0 in consecutive cycles
    pkt_dest = 4'd5; pkt_size = 5'd3; pkt_valid = 1'b1; dat_valid = 1'b1; dat_in = 32'hA0;
    #1;
    chk("t1_accept_ready", d0_pkt_ready, 1'b1);
    chk("t1_accept_nowr", d0_flit_wr, 1'b0);
    tick();
    pkt_valid = 1'b0; dat_in = 32'hA1;
    #1;
    chk("t1_head_wr", d0_flit_wr, 1'b1);
    chk("t1_head_hd", d0_flit_hd, 1'b1);
    chk("t1_head_tl", d0_flit_tl, 1'b0);
    chk("t1_head_vc", d0_flit_vc, 2'b01);
    chk("t1_head_pld", d0_flit_pld, 32'h52);
    chk("t1_head_busy", d0_busy, 1'b1);
    chk("t1_head_pkt_ready", d0_pkt_ready, 1'b0);
    chk("t1_head_dat_ready", d0_dat_ready, 1'b0);
    tick();
    #1;
    chk("t1_body_wr", d0_flit_wr, 1'b1);
    chk("t1_body_hd", d0_flit_hd, 1'b0);
    chk("t1_body_tl", d0_flit_tl, 1'b0);
    chk("t1_body_pld", d0_flit_pld, 32'hA1);
    chk("t1_body_dat_ready", d0_dat_ready, 1'b1);
    tick();
    dat_in = 32'hA2;
    #1;
    chk("t1_tail_wr", d0_flit_wr, 1'b1);
    chk("t1_tail_tl", d0_flit_tl, 1'b1);
    chk("t1_tail_vc", d0_flit_vc, 2'b01);
    chk("t1_tail_pld", d0_flit_pld, 32'hA2);
    tick();
    #1;
    chk("t1_after_wr", d0_flit_wr, 1'b0);
    chk("t1_after_vc", d0_flit_vc, 2'b00);
    chk("t1_after_busy", d0_busy, 1'b0);
    chk("t1_after_dat_ready", d0_dat_ready, 1'b0);
    chk("t1_cnt0", d0.w_cred_cnt[0], 3'd1);
    dat_valid = 1'b0;
    give_credit(2'b01, 3);
    #1;
    chk("t1_cnt0_restored", d0.w_cred_cnt[0], 3'd4);

    // Size 1 and size 0 (clamped to 1): single head+tail flit
    pkt_dest = 4'd3; pkt_size = 5'd1; pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
    #1;
    chk("t2_s1_hd", d0_flit_hd, 1'b1);
    chk("t2_s1_tl", d0_flit_tl, 1'b1);
    chk("t2_s1_pld", d0_flit_pld, 32'h32);
    tick();
    #1;
    chk("t2_s1_idle_busy", d0_busy, 1'b0);
    chk("t2_s1_idle_ready", d0_pkt_ready, 1'b1);
    chk("t2_s1_idle_wr", d0_flit_wr, 1'b0);
    pkt_dest = 4'hF; pkt_size = 5'd0; pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
    #1;
    chk("t2_s0_wr", d0_flit_wr, 1'b1);
    chk("t2_s0_tl", d0_flit_tl, 1'b1);
    chk("t2_s0_pld", d0_flit_pld, 32'hF2);
    tick();
    #1;
    chk("t2_s0_idle_busy", d0_busy, 1'b0);
    chk("t2_cnt0", d0.w_cred_cnt[0], 3'd2);
    give_credit(2'b01, 2);

    // VC0 drained, VC1 full: size 2 goes on VC1
    send_quiet(4'd9, 5'd4);
    pkt_dest = 4'd6; pkt_size = 5'd2; pkt_valid = 1'b1;
    #1;
    chk("t3_cnt0_empty", d0.w_cred_cnt[0], 3'd0);
    chk("t3_ready_vc1", d0_pkt_ready, 1'b1);
    tick();
    pkt_valid = 1'b0; dat_valid = 1'b1; dat_in = 32'hB1;
    #1;
    chk("t3_head_vc", d0_flit_vc, 2'b10);
    chk("t3_head_pld", d0_flit_pld, 32'h62);
    chk("t3_head_tl", d0_flit_tl, 1'b0);
    tick();
    #1;
    chk("t3_tail_vc", d0_flit_vc, 2'b10);
    chk("t3_tail_tl", d0_flit_tl, 1'b1);
    chk("t3_tail_pld", d0_flit_pld, 32'hB1);
    tick();
    dat_valid = 1'b0;
    #1;
    chk("t3_cnt0_untouched", d0.w_cred_cnt[0], 3'd0);
    chk("t3_cnt1", d0.w_cred_cnt[1], 3'd2);
    give_credit(2'b01, 4);
    give_credit(2'b10, 2);

    // Credit with counter already at B
    #1;
    chk("t4_cnt0_full", d0.w_cred_cnt[0], 3'd4);
    chk("t4_no_err", d0_cred_err, 1'b0);
    give_credit(2'b01, 1);
    #1;
    chk("t4_cnt0_stays", d0.w_cred_cnt[0], 3'd4);
    chk("t4_err_set", d0_cred_err, 1'b1);
    tick();
    #1;
    chk("t4_err_sticky", d0_cred_err, 1'b1);

    // Reset after the head of a size-4 packet
    pkt_dest = 4'd1; pkt_size = 5'd4; pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0; dat_valid = 1'b1; dat_in = 32'hC0;
    #1;
    chk("t5_head_wr", d0_flit_wr, 1'b1);
    chk("t5_head_hd", d0_flit_hd, 1'b1);
    tick();
    reset = 1'b1;
    #1;
    chk("t5_rst_pkt_ready", d0_pkt_ready, 1'b0);
    chk("t5_rst_dat_ready", d0_dat_ready, 1'b0);
    chk("t5_rst_wr", d0_flit_wr, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk("t5_post_ready", d0_pkt_ready, 1'b1);
    chk("t5_post_wr", d0_flit_wr, 1'b0);
    chk("t5_post_busy", d0_busy, 1'b0);
    chk("t5_post_cnt0", d0.w_cred_cnt[0], 3'd4);
    chk("t5_post_err", d0_cred_err, 1'b0);
    tick();
    #1;
    chk("t5_no_more_flits", d0_flit_wr, 1'b0);
    dat_valid = 1'b0;

    // B=2 instance: size 5 stalls after 2 flits, then resumes with credits
    do_reset();
    pkt_dest = 4'd7; pkt_size = 5'd5; pkt_valid = 1'b1; dat_valid = 1'b1; dat_in = 32'hD0;
    #1;
    chk("t6_ready", d1_pkt_ready, 1'b1);
    tick();
    pkt_valid = 1'b0;
    #1;
    chk("t6_head_wr", d1_flit_wr, 1'b1);
    chk("t6_head_hd", d1_flit_hd, 1'b1);
    chk("t6_head_pld", d1_flit_pld, 32'h72);
    tick();
    dat_in = 32'hD1;
    #1;
    chk("t6_body1_wr", d1_flit_wr, 1'b1);
    chk("t6_body1_pld", d1_flit_pld, 32'hD1);
    tick();
    dat_in = 32'hD2;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t6_stall_wr", d1_flit_wr, 1'b0);
      chk("t6_stall_dat_ready", d1_dat_ready, 1'b0);
      chk("t6_stall_vc", d1_flit_vc, 2'b00);
      chk("t6_stall_cnt", d1.w_cred_cnt[0], 2'd0);
      tick();
    end
    credit_in = 2'b01;
    #1;
    chk("t6_credit_nowr", d1_flit_wr, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      dat_in = 32'hD2 + 32'(i);
      #1;
      chk("t6_resume_cnt", d1.w_cred_cnt[0], 2'd1);
      chk("t6_resume_wr", d1_flit_wr, 1'b1);
      chk("t6_resume_pld", d1_flit_pld, 32'hD2 + 32'(i));
      chk("t6_resume_tl", d1_flit_tl, (i == 2) ? 1'b1 : 1'b0);
      tick();
    end
    credit_in = '0; dat_valid = 1'b0;
    #1;
    chk("t6_end_cnt", d1.w_cred_cnt[0], 2'd1);
    chk("t6_end_busy", d1_busy, 1'b0);
    chk("t6_end_wr", d1_flit_wr, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ni_flit_injector.md
NI_FLIT_INJECTOR -- requirements
Module: ni_flit_injector

Interface
REQ-001 SHALL have parameter NOC_ID, default 0: NoC instance whose configuration (V, B, Fpay, EAw) the block takes.
REQ-002 SHALL have parameter EP_ID, default 0: endpoint index of this port in the fat-tree, 0..NE-1.
REQ-003 SHALL have parameter MAX_PKT, default 16: maximum packet length in flits.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk input 1 rising-edge clock; reset input 1 synchronous active-high reset.
REQ-005 SHALL have port pkt_valid, input, 1 bit: packet request.
REQ-006 SHALL have port pkt_ready, output, 1 bit: request accepted.
REQ-007 SHALL have port pkt_dest, input, EAw bits: destination endpoint address.
REQ-008 SHALL have port pkt_size, input, $clog2(MAX_PKT+1) bits: total flits including the head.
REQ-009 SHALL have port dat_valid, input, 1 bit: payload word available.
REQ-010 SHALL have port dat_ready, output, 1 bit: payload word consumed.
REQ-011 SHALL have port dat_in, input, Fpay bits: payload word.
REQ-012 SHALL have port flit_wr, output, 1 bit: flit valid this cycle.
REQ-013 SHALL have port flit_hd, output, 1 bit: head marker. Port flit_tl, output, 1 bit: tail marker.
REQ-014 SHALL have port flit_vc, output, V bits: one-hot VC.
REQ-015 SHALL have port flit_pld, output, Fpay bits: payload.
REQ-016 SHALL have port credit_in, input, V bits: one credit returned per VC per cycle from the edge router.
REQ-017 SHALL have port busy, output, 1 bit: packet in progress.
REQ-018 SHALL have port cred_err, output, 1 bit: sticky credit overflow.

Function
REQ-019 SHALL keep one credit counter per VC, width $clog2(B+1), reset value B.
REQ-020 Credit counter update SHALL be: send only -> -1; credit only -> +1; both in the same cycle -> unchanged.
REQ-021 A credit arriving at a counter equal to B SHALL leave the counter at B and set cred_err until reset.
REQ-022 FSM states SHALL be IDLE, HEAD, BODY; the reset state is IDLE.
REQ-023 In IDLE, pkt_ready SHALL be 1 only when some VC has credit > 0.
REQ-024 On pkt_valid&&pkt_ready the block SHALL latch pkt_dest and pkt_size, and latch the lowest-index VC with credit > 0 as the packet VC. The size is clamped: 0 becomes 1; a value above MAX_PKT becomes MAX_PKT. Next state is HEAD.
REQ-025 In HEAD, flit_wr SHALL assert in the same cycle that the packet VC credit is > 0, with:
- flit_hd=1;
- flit_pld = {zero-extension, latched dest, EP_ID[EAw-1:0]}, source in the LSBs;
- flit_tl=1 iff the latched size is 1.
REQ-026 From HEAD: a head flit with tail goes to IDLE; any other sent head flit goes to BODY.
REQ-027 In BODY:
- dat_ready = (packet VC credit > 0);
- flit_wr = dat_valid && dat_ready, with flit_pld = dat_in and flit_hd=0;
- flit_tl=1 on the flit that completes the latched size, after which the state returns to IDLE.
REQ-028 All packet flits SHALL use the same VC. flit_vc SHALL be 0 whenever flit_wr=0.
REQ-029 Latency SHALL be: request accepted in cycle t -> earliest head flit at t+1 -> earliest body flit at t+2. Throughput is 1 flit per cycle when credits are available.
REQ-030 pkt_ready SHALL be 0 outside IDLE, and dat_ready SHALL be 0 outside BODY.
REQ-031 busy SHALL be 1 in HEAD and BODY.
REQ-032 The block SHALL never emit a flit on a VC whose counter is 0.

Reset
REQ-033 Reset SHALL act synchronously and override all other activity.
REQ-034 Reset SHALL set: FSM IDLE, credit counters B, cred_err 0, flit_wr 0, flit_vc 0, busy 0.
REQ-035 Reset mid-packet SHALL abandon the packet: no tail flit is emitted and no residual state remains.
REQ-036 pkt_ready and dat_ready SHALL be 0 during any cycle with reset=1.

Structure
REQ-037 The FSM state enum and the flit-header field helpers SHALL live in the shared NoC package, alongside the smartflit_chanel_t definitions.
REQ-038 Per-VC credit counters SHALL be one sub-module, ni_credit_counter, instantiated V times.
REQ-039 Packing into smartflit_chanel_t for the endpoint ports of fattree_noc_top SHALL be done by the instantiating NI, not by this block.

Verification
REQ-040 Reset, then V=2, B=4, send size 3 to dest 5 from EP_ID 2 -> head/body/tail on VC0 in 3 consecutive cycles, head payload dest 5 / src 2, VC0 credit 1.
REQ-041 Size 1 request -> a single flit with hd=1 and tl=1; FSM back in IDLE the next cycle.
REQ-042 VC0 credit 0, VC1 credit 4, size 2 -> both flits on VC1, VC0 untouched.
REQ-043 B=2, size 5, credits withheld -> exactly 2 flits are sent and the block stalls. Then 1 credit per cycle is returned in the same cycles that flits are sent -> the counter holds, with no gap once credits return.
REQ-044 Credit pulse with the counter at B -> counter stays B and cred_err=1 until reset.
REQ-045 Reset asserted after the head of a size-4 packet -> no further flits, pkt_ready=1 on the first cycle after reset, credits back to B.
